series_ctrl: RTL
================

# series_ctrl

Parametrised control FSM for the iterative series evaluator (cosine and related Taylor-series datapaths). It adds three things over the fixed-sequence controller:
- a multi-cycle multiply handshake;
- a term counter with an optional hard term limit;
- a synchronous abort.

It sits between the user start/stop pins and the accumulate/multiply datapath. It drives one-hot-style enables and reports busy/done status.

## Interface
Parameters:
- TERM_W, 5: width of the term counter.
- MAX_TERMS, 16: maximum number of accumulate steps when the limit is compiled in. Legal range is 1..2^TERM_W.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rst  in  1  reset, asynchronous, active-high.
- start  in  1  user start. A calculation is armed while start is high and launched when it is released.
- stop  in  1  convergence flag from the datapath, sampled only in ACCUM.
- mul_done  in  1  datapath multiply-complete strobe, sampled only in MULT.
- abort  in  1  synchronous cancel. Highest priority after rst.
- state  out  3  current state encoding (below).
- load  out  1  initialise datapath registers; high in INIT.
- acc_en  out  1  add current term to the sum; high in ACCUM.
- mul_start  out  1  high only on the first cycle of each MULT visit.
- fin_en  out  1  compute final result; high in FINISH.
- busy  out  1  high in INIT, ACCUM, MULT, FINISH.
- done  out  1  single-cycle pulse, coincident with FINISH.
- term_cnt  out  TERM_W  number of completed ACCUM→MULT transitions since INIT.
- limit_hit  out  1  the last calculation ended on the term limit, not on stop.

## Operation
- States: IDLE=0, ARMED=1, INIT=2, ACCUM=3, FINISH=4, MULT=5. Codes 6 and 7 are illegal and go to IDLE on the next edge.
- IDLE → ARMED when start=1.
- ARMED → INIT when start=0; stays in ARMED while start=1.
- INIT → ACCUM unconditionally. INIT clears term_cnt to 0 and limit_hit to 0.
- ACCUM → FINISH when stop=1 or the limit condition holds; otherwise ACCUM → MULT with term_cnt+1.
- MULT → ACCUM when mul_done=1, including on the first MULT cycle. Otherwise stays in MULT, with mul_start low after the first cycle.
- FINISH → IDLE unconditionally. A second start pulse is only recognised once back in IDLE.
- abort=1 in any state other than IDLE → IDLE on the next edge. On abort: no done, no fin_en, term_cnt and limit_hit hold their values.
- Priority: rst > abort > stop > limit > normal transition. When stop and limit are both true, go to FINISH with limit_hit=0.
- All outputs are decoded from registered state and counters; there are no combinational paths from inputs to outputs.
- Reset values:
  - state=IDLE, term_cnt=0, limit_hit=0.
  - load, acc_en, mul_start, fin_en, busy, done all 0.
- rst mid-calculation returns to IDLE immediately (asynchronously), with no done pulse.

## Timing
- Minimum calculation: 1 INIT, 1 ACCUM, 1 FINISH = 3 busy cycles after the start-release edge.
- Each extra term costs 1 ACCUM cycle plus N MULT cycles, where N ≥ 1 is the cycle count through mul_done.
- Latency from start sampled low in ARMED to load high is 1 cycle.
- done rises in the cycle after the terminating ACCUM.
- term_cnt updates on the ACCUM→MULT edge, so it is stable throughout MULT and the following ACCUM.

## Configuration
- SERIES_TERM_LIMIT_EN defined:
  - In ACCUM, the limit condition is term_cnt == MAX_TERMS-1 with stop=0. This forces FINISH and sets limit_hit=1.
  - At most MAX_TERMS ACCUM cycles per calculation.
- SERIES_TERM_LIMIT_EN undefined:
  - No limit condition; only stop or abort ends ACCUM.
  - term_cnt wraps modulo 2^TERM_W.
  - limit_hit is tied to 0.

## Test plan
- Reset and idle: rst pulse mid-MULT → state=0, all outputs 0 in the same cycle. Then start=1 for 3 cycles, then 0 → states go 1,1,1,2,3.
- Immediate stop: stop=1 on the first ACCUM → FINISH with done=1 for exactly one cycle, term_cnt=0, limit_hit=0, then IDLE.
- Multi-term with slow multiplier: mul_done asserted 4 cycles after each mul_start, stop on the 3rd ACCUM →
  - mul_start pulses exactly twice;
  - term_cnt=2 at FINISH;
  - busy for 1+3+2×4+1=13 cycles.
- Limit, macro on, MAX_TERMS=16, stop held 0 → 16 ACCUM cycles, FINISH with term_cnt=15 and limit_hit=1. Same run with stop=1 on the 16th ACCUM → limit_hit=0.
- Limit, macro off, TERM_W=5: stop on the 35th ACCUM → term_cnt=2 (wrapped), limit_hit=0.
- Abort: abort=1 during the 2nd MULT cycle → IDLE next edge, no done, term_cnt held. A new start release then reaches INIT with term_cnt cleared to 0.

Source files
------------

// File: rtl/series_if.sv
// series_if: start/stop/multiply handshake and status bundle between the
// series evaluator controller (slave side) and the user pins plus the
// accumulate/multiply datapath (master side).
interface series_if #(
   parameter int TERM_W = 5
);
   logic              start;
   logic              stop;
   logic              mul_done;
   logic              abort;
   logic [2:0]        state;
   logic              load;
   logic              acc_en;
   logic              mul_start;
   logic              fin_en;
   logic              busy;
   logic              done;
   logic [TERM_W-1:0] term_cnt;
   logic              limit_hit;

   modport master (
      output start, stop, mul_done, abort,
      input  state, load, acc_en, mul_start, fin_en, busy, done, term_cnt, limit_hit
   );

   modport slave (
      input  start, stop, mul_done, abort,
      output state, load, acc_en, mul_start, fin_en, busy, done, term_cnt, limit_hit
   );
endinterface

// File: rtl/series_ctrl.sv
// series_ctrl: control FSM for the iterative Taylor-series evaluator.
// Sequences INIT -> ACCUM -> (MULT -> ACCUM)* -> FINISH, with a multi-cycle
// multiply handshake, a term counter and a synchronous abort.
// Optional feature: define SERIES_TERM_LIMIT_EN to force FINISH once
// MAX_TERMS accumulate steps have been taken (sets limit_hit).
// Every output is decoded from registered state only.
module series_ctrl #(
   parameter int TERM_W    = 5,
   parameter int MAX_TERMS = 16
) (
   input  logic     clk,
   input  logic     rst,
   series_if.slave  bus
);

   typedef enum logic [2:0] {
      S_IDLE   = 3'd0,
      S_ARMED  = 3'd1,
      S_INIT   = 3'd2,
      S_ACCUM  = 3'd3,
      S_FINISH = 3'd4,
      S_MULT   = 3'd5
   } state_t;

   if (MAX_TERMS < 1 || MAX_TERMS > (1 << TERM_W)) begin : g_max_terms_illegal
      $error("series_ctrl: MAX_TERMS must lie in 1..2**TERM_W");
   end

   state_t            state_q, state_d;
   logic [TERM_W-1:0] term_cnt_q, term_cnt_d;
   logic              limit_hit_q, limit_hit_d;
   logic              mul_first_q, mul_first_d;
   logic              limit_cond;

`ifdef SERIES_TERM_LIMIT_EN
   localparam logic [TERM_W-1:0] LIMIT_VAL = TERM_W'(MAX_TERMS - 1);
   // The last permitted ACCUM is the one entered with MAX_TERMS-1 completed terms.
   assign limit_cond = (term_cnt_q == LIMIT_VAL);
`else
   // No hard limit: only stop or abort ends ACCUM; term_cnt wraps freely.
   assign limit_cond = 1'b0;
`endif

   // State, term counter, limit flag and first-MULT-cycle marker registers.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q     <= S_IDLE;
         term_cnt_q  <= '0;
         limit_hit_q <= 1'b0;
         mul_first_q <= 1'b0;
      end else begin
         state_q     <= state_d;
         term_cnt_q  <= term_cnt_d;
         limit_hit_q <= limit_hit_d;
         mul_first_q <= mul_first_d;
      end
   end

   // Next-state logic: abort beats stop, stop beats the term limit.
   always_comb begin
      state_d     = state_q;
      term_cnt_d  = term_cnt_q;
      limit_hit_d = limit_hit_q;
      mul_first_d = 1'b0;
      if (bus.abort && state_q != S_IDLE) begin
         // Counters hold so software can see how far the cancelled run got.
         state_d = S_IDLE;
      end else begin
         case (state_q)
            S_IDLE:   if (bus.start) state_d = S_ARMED;
            S_ARMED: begin
               if (!bus.start) begin
                  // Clear on entry so INIT already shows a fresh count.
                  state_d     = S_INIT;
                  term_cnt_d  = '0;
                  limit_hit_d = 1'b0;
               end
            end
            S_INIT:   state_d = S_ACCUM;
            S_ACCUM: begin
               if (bus.stop) begin
                  state_d = S_FINISH;
               end else if (limit_cond) begin
                  state_d     = S_FINISH;
                  limit_hit_d = 1'b1;
               end else begin
                  state_d     = S_MULT;
                  term_cnt_d  = term_cnt_q + 1'b1;
                  mul_first_d = 1'b1;
               end
            end
            S_MULT:   if (bus.mul_done) state_d = S_ACCUM;
            S_FINISH: state_d = S_IDLE;
            default:  state_d = S_IDLE;
         endcase
      end
   end

   assign bus.state     = state_q;
   assign bus.load      = (state_q == S_INIT);
   assign bus.acc_en    = (state_q == S_ACCUM);
   assign bus.mul_start = (state_q == S_MULT) && mul_first_q;
   assign bus.fin_en    = (state_q == S_FINISH);
   assign bus.done      = (state_q == S_FINISH);
   assign bus.busy      = (state_q == S_INIT) || (state_q == S_ACCUM) ||
                          (state_q == S_MULT) || (state_q == S_FINISH);
   assign bus.term_cnt  = term_cnt_q;
   assign bus.limit_hit = limit_hit_q;

endmodule
